// File: rtl/switch_event_capture.sv
// switch_event_capture: synchronizes and debounces board switches, publishes the stable
// value and raises stable-value changes as events on a valid/ack handshake.
// Define SWITCH_DEBOUNCE_EN to build the per-bit debounce counters; otherwise stable follows sync2.
module switch_event_capture #(
  parameter int SWITCH_NUM      = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                  clk,
  input  logic                  resetNeg,
  input  logic [SWITCH_NUM-1:0] switches,
  output logic [SWITCH_NUM-1:0] swStable,
  output logic                  eventValid,
  output logic [SWITCH_NUM-1:0] eventData,
  output logic [SWITCH_NUM-1:0] eventMask,
  output logic                  eventOverrun,
  input  logic                  eventAck
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                state, state_next;
  logic [SWITCH_NUM-1:0] sync1, sync2;
  logic [SWITCH_NUM-1:0] upd;
  logic [SWITCH_NUM-1:0] stable_next, data_next, mask_next;
  logic                  overrun_next;

  // Elaboration-time guard: an illegal counter configuration yields this empty marker scope.
  if (DEBOUNCE_CYCLES < 1 ||
      (longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_debounce_cfg
  end

  assign stable_next = swStable ^ upd;

  always_ff @(posedge clk or negedge resetNeg) begin
    if (!resetNeg) begin
      sync1    <= '0;
      sync2    <= '0;
      swStable <= '0;
    end else begin
      sync1    <= switches;
      sync2    <= sync1;
      swStable <= stable_next;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt [SWITCH_NUM];

  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < SWITCH_NUM; i++) begin
      upd[i] = (sync2[i] != swStable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // A counter restarts whenever its bit agrees with swStable, so short glitches never qualify.
  always_ff @(posedge clk or negedge resetNeg) begin
    if (!resetNeg) begin
      for (int unsigned i = 0; i < SWITCH_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SWITCH_NUM; i++) begin
        if (sync2[i] == swStable[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  always_comb begin
    upd = sync2 ^ swStable;
  end
`endif

  always_ff @(posedge clk or negedge resetNeg) begin
    if (!resetNeg) begin
      state        <= IDLE;
      eventData    <= '0;
      eventMask    <= '0;
      eventOverrun <= 1'b0;
    end else begin
      state        <= state_next;
      eventData    <= data_next;
      eventMask    <= mask_next;
      eventOverrun <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state;
    data_next    = eventData;
    mask_next    = eventMask;
    overrun_next = eventOverrun;
    eventValid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|upd) begin
          data_next    = stable_next;
          mask_next    = upd;
          overrun_next = 1'b0;
          state_next   = PENDING;
        end
      end
      PENDING: begin
        eventValid = 1'b1;
        // An ack coinciding with a new change retires the old event and opens a fresh one.
        if (eventAck) begin
          overrun_next = 1'b0;
          if (|upd) begin
            data_next = stable_next;
            mask_next = upd;
          end else begin
            state_next = IDLE;
          end
        end else if (|upd) begin
          data_next    = stable_next;
          mask_next    = eventMask | upd;
          overrun_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
